// File: rtl/ahb_copy_master.sv
// Word-by-word AHB-Lite copy engine: one single read then one single write per word.
// Optional build macro AHB_COPY_ERR_EN enables abort on an ERROR response.
module ahb_copy_master #(
  parameter int LENWIDTH = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LENWIDTH-1:0] len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         HADDR,
  output logic [1:0]          HTRANS,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [2:0]          HBURST,
  output logic [3:0]          HPROT,
  output logic                HMASTLOCK,
  output logic [31:0]         HWDATA,
  input  logic                HREADY,
  input  logic [31:0]         HRDATA,
  input  logic                HRESP,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_t              state;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LENWIDTH-1:0] cnt;
  logic [31:0]         buffer;

  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign state_dbg = state;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

`ifndef AHB_COPY_ERR_EN
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign err = 1'b0;
`endif

  // Outputs are registered: each transition loads the values the next state drives.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      src    <= '0;
      dst    <= '0;
      cnt    <= '0;
      buffer <= '0;
      HADDR  <= '0;
      HTRANS <= TR_IDLE;
      HWRITE <= 1'b0;
      HWDATA <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef AHB_COPY_ERR_EN
      err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef AHB_COPY_ERR_EN
            err <= 1'b0;
`endif
            if (len != '0) begin
              src    <= {src_addr[31:2], 2'b00};
              dst    <= {dst_addr[31:2], 2'b00};
              cnt    <= len;
              HADDR  <= {src_addr[31:2], 2'b00};
              HTRANS <= TR_NONSEQ;
              HWRITE <= 1'b0;
              busy   <= 1'b1;
              state  <= S_RD_ADDR;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RD_ADDR: begin
          if (HREADY) begin
            HTRANS <= TR_IDLE;
            state  <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
`ifdef AHB_COPY_ERR_EN
          if (HRESP) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else
`endif
          if (HREADY) begin
            buffer <= HRDATA;
            HWDATA <= HRDATA;
            HADDR  <= dst;
            HTRANS <= TR_NONSEQ;
            HWRITE <= 1'b1;
            state  <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (HREADY) begin
            HTRANS <= TR_IDLE;
            HWDATA <= buffer;
            state  <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
`ifdef AHB_COPY_ERR_EN
          if (HRESP) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else
`endif
          if (HREADY) begin
            src <= src + 32'd4;
            dst <= dst + 32'd4;
            cnt <= cnt - LENWIDTH'(1);
            if (cnt == LENWIDTH'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              HADDR  <= src + 32'd4;
              HTRANS <= TR_NONSEQ;
              HWRITE <= 1'b0;
              state  <= S_RD_ADDR;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          busy   <= 1'b0;
          HTRANS <= TR_IDLE;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_copy_master.sv
// Directed bench for ahb_copy_master with a small AHB slave that returns addr ^ 0xCAFE0000.
module tb_ahb_copy_master;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST, state_dbg;
  logic [3:0]  HPROT;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  ahb_copy_master #(.LENWIDTH(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .state_dbg(state_dbg)
  );

  always #5 HCLK = ~HCLK;

  // Slave data-phase tracker
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr = '0;
  always @(posedge HCLK) begin
    if (HTRANS == 2'b10 && HREADY) begin
      dp_valid <= 1'b1;
      dp_addr  <= HADDR;
      dp_write <= HWRITE;
    end else if (HREADY) begin
      dp_valid <= 1'b0;
    end
  end
  assign HRDATA = dp_addr ^ 32'hCAFE_0000;

  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  int done_cyc, n_done, n_busy, n_nonseq, stab_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int waits, input int err_rd, input int restart_cyc);
    int wctr = 0;
    logic prev_sa = 1'b0, prev_sd = 1'b0;
    logic [31:0] prev_a = '0, prev_d = '0;
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    done_cyc = 0; n_done = 0; n_busy = 0; n_nonseq = 0; stab_err = 0;
    src_addr = s; dst_addr = d; len = n; start = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK);
    for (int c = 1; c <= 120; c++) begin
      if (c > 1) @(posedge HCLK);
      #1;
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        src_addr = 32'h0000_0900; dst_addr = 32'h0000_0A00; len = 16'd5;
      end
      HREADY = (wctr == waits);
      HRESP = (err_rd != 0) && dp_valid && !dp_write && (rd_log.size() == err_rd);
      @(negedge HCLK);
      if (done) begin n_done++; if (done_cyc == 0) done_cyc = c; end
      if (busy) n_busy++;
      if (HTRANS == 2'b10) n_nonseq++;
      if (prev_sa && (HTRANS != 2'b10 || HADDR != prev_a)) stab_err++;
      if (prev_sd && HWDATA != prev_d) stab_err++;
      if (HTRANS == 2'b10 && HREADY) begin
        if (HWRITE) wa_log.push_back(HADDR); else rd_log.push_back(HADDR);
      end
      if (dp_valid && dp_write && HREADY) wd_log.push_back(HWDATA);
      prev_sa = (HTRANS == 2'b10) && !HREADY;
      prev_sd = dp_valid && dp_write && !HREADY;
      prev_a = HADDR; prev_d = HWDATA;
      wctr = HREADY ? 0 : wctr + 1;
      if (done_cyc != 0 && c >= done_cyc + 2) break;
    end
    check_eq("copy_finished", 32'(done_cyc != 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_htrans", 32'(HTRANS), 32'd0);
    check_eq("rst_haddr", HADDR, 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    check_eq("const_ctrl", {16'd0, HSIZE, HBURST, HPROT, HMASTLOCK, 5'd0}, {16'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 5'd0});
    @(negedge HCLK); HRESETn = 1'b1;
    @(negedge HCLK);

    // Three words, no waits
    run_copy(32'h100, 32'h200, 16'd3, 0, 0, 0);
    check_eq("t1_done_cyc", done_cyc, 13);
    check_eq("t1_done_len", n_done, 1);
    check_eq("t1_busy_cnt", n_busy, 12);
    check_eq("t1_rd0", q_at(rd_log, 0), 32'h100);
    check_eq("t1_rd1", q_at(rd_log, 1), 32'h104);
    check_eq("t1_rd2", q_at(rd_log, 2), 32'h108);
    check_eq("t1_wa0", q_at(wa_log, 0), 32'h200);
    check_eq("t1_wa2", q_at(wa_log, 2), 32'h208);
    check_eq("t1_wd0", q_at(wd_log, 0), 32'hCAFE_0100);
    check_eq("t1_wd1", q_at(wd_log, 1), 32'hCAFE_0104);
    check_eq("t1_wd2", q_at(wd_log, 2), 32'hCAFE_0108);
    check_eq("t1_nwr", wd_log.size(), 3);

    // One word, two wait states per phase
    run_copy(32'h40, 32'h80, 16'd1, 2, 0, 0);
    check_eq("t2_done_cyc", done_cyc, 13);
    check_eq("t2_stable", stab_err, 0);
    check_eq("t2_wa0", q_at(wa_log, 0), 32'h80);
    check_eq("t2_wd0", q_at(wd_log, 0), 32'hCAFE_0040);

    // Zero length
    run_copy(32'h100, 32'h200, 16'd0, 0, 0, 0);
    check_eq("t3_done_cyc", done_cyc, 1);
    check_eq("t3_busy_cnt", n_busy, 0);
    check_eq("t3_nonseq", n_nonseq, 0);

    // Address wrap-around
    run_copy(32'hFFFF_FFFC, 32'h10, 16'd2, 0, 0, 0);
    check_eq("t4_done_cyc", done_cyc, 9);
    check_eq("t4_rd0", q_at(rd_log, 0), 32'hFFFF_FFFC);
    check_eq("t4_rd1", q_at(rd_log, 1), 32'h0);
    check_eq("t4_wa1", q_at(wa_log, 1), 32'h14);
    check_eq("t4_wd1", q_at(wd_log, 1), 32'hCAFE_0000);

    // Unaligned command and a second start while busy
    run_copy(32'h303, 32'h402, 16'd1, 0, 0, 2);
    check_eq("t5_done_cyc", done_cyc, 5);
    check_eq("t5_rd0", q_at(rd_log, 0), 32'h300);
    check_eq("t5_wa0", q_at(wa_log, 0), 32'h400);
    check_eq("t5_nrd", rd_log.size(), 1);

    // ERROR response on the second read
    run_copy(32'h500, 32'h600, 16'd4, 0, 2, 0);
`ifdef AHB_COPY_ERR_EN
    check_eq("t6_done_cyc", done_cyc, 7);
    check_eq("t6_err", 32'(err), 32'd1);
    check_eq("t6_nwr", wd_log.size(), 1);
`else
    check_eq("t6_done_cyc", done_cyc, 17);
    check_eq("t6_err", 32'(err), 32'd0);
    check_eq("t6_nwr", wd_log.size(), 4);
    check_eq("t6_wd3", q_at(wd_log, 3), 32'hCAFE_050C);
`endif

    // Reset asserted in the middle of WR_DATA
    src_addr = 32'h700; dst_addr = 32'h800; len = 16'd2; start = 1'b1; HREADY = 1'b1;
    @(posedge HCLK); #1 start = 1'b0;
    for (int c = 0; c < 20 && state_dbg != 3'd4; c++) @(negedge HCLK);
    check_eq("t7_reached_wr_data", 32'(state_dbg), 32'd4);
    #1 HRESETn = 1'b0;
    #1;
    check_eq("t7_htrans", 32'(HTRANS), 32'd0);
    check_eq("t7_haddr", HADDR, 32'd0);
    check_eq("t7_hwdata", HWDATA, 32'd0);
    check_eq("t7_misc", {28'd0, HWRITE, busy, done, err}, 32'd0);
    check_eq("t7_state", 32'(state_dbg), 32'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(negedge HCLK);

    // Clean copy after reset
    run_copy(32'h20, 32'h30, 16'd1, 0, 0, 0);
    check_eq("t8_done_cyc", done_cyc, 5);
    check_eq("t8_wd0", q_at(wd_log, 0), 32'hCAFE_0020);
    check_eq("t8_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
